reg_scoreboard: RTL and testbench

- Tracks outstanding register writes between the decode stage and write-back, one saturating counter per architectural register R0–R14.
- Sits beside the register file. It watches the ID-stage source and destination addresses and the WB-stage write port (wb_en/wb_dest, the same signals that drive the register file write).
- Raises hazard so the IF/ID registers freeze and a bubble is inserted into ID/EX until every needed source has been written back.

---
 rtl/reg_scoreboard_if.sv | 40 ++++
 rtl/reg_scoreboard.sv | 89 ++++++++
 tb/tb_reg_scoreboard.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Bundle of ID-stage issue, WB-stage write port and scoreboard status signals.
// The optional stall_cnt signal exists only when SCOREBOARD_STATS_EN is defined.
interface reg_scoreboard_if #(
  parameter int unsigned NUM_REGS = 15,
  parameter int unsigned ADDR_W   = 4
);
  logic                issue_valid;
  logic                issue_wb_en;
  logic [ADDR_W-1:0]   issue_dest;
  logic [ADDR_W-1:0]   src1;
  logic [ADDR_W-1:0]   src2;
  logic                two_src;
  logic                flush;
  logic                wb_en;
  logic [ADDR_W-1:0]   wb_dest;
  logic                hazard;
  logic [NUM_REGS-1:0] busy_mask;
  logic                underflow_err;
`ifdef SCOREBOARD_STATS_EN
  logic [15:0]         stall_cnt;
`endif

  modport master (
    output issue_valid, issue_wb_en, issue_dest, src1, src2, two_src, flush,
    output wb_en, wb_dest,
`ifdef SCOREBOARD_STATS_EN
    input  stall_cnt,
`endif
    input  hazard, busy_mask, underflow_err
  );

  modport slave (
    input  issue_valid, issue_wb_en, issue_dest, src1, src2, two_src, flush,
    input  wb_en, wb_dest,
`ifdef SCOREBOARD_STATS_EN
    output stall_cnt,
`endif
    output hazard, busy_mask, underflow_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters with RAW/WAW-limit stall.
// Optional feature macro SCOREBOARD_STATS_EN adds a saturating stall cycle counter.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 15,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    count_q [NUM_REGS];
  logic [CNT_W-1:0]    count_d [NUM_REGS];
  logic [CNT_W-1:0]    eff     [NUM_REGS];
  logic                underflow_q, underflow_d;
  logic [NUM_REGS-1:0] hit, dec, busy_now, busy_eff, full_eff;
  logic                src1_haz, src2_haz, dest_haz;
  logic                hazard_c, issue_fire;

  // Effective counts see same-cycle write-back since the RF writes on the falling edge
  always_comb begin
    hit = '0;
    dec = '0;
    busy_now = '0;
    busy_eff = '0;
    full_eff = '0;
    src1_haz = 1'b0;
    src2_haz = 1'b0;
    dest_haz = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_now[r] = (count_q[r] != '0);
      hit[r]      = sb.wb_en && (sb.wb_dest == ADDR_W'(r));
      dec[r]      = hit[r] && busy_now[r];
      eff[r]      = count_q[r] - CNT_W'(dec[r]);
      busy_eff[r] = (eff[r] != '0);
      full_eff[r] = (eff[r] == CNT_MAX);
      if (sb.src1 == ADDR_W'(r) && busy_eff[r]) src1_haz = 1'b1;
      if (sb.src2 == ADDR_W'(r) && busy_eff[r]) src2_haz = 1'b1;
      if (sb.issue_dest == ADDR_W'(r) && full_eff[r]) dest_haz = 1'b1;
    end
    hazard_c = sb.issue_valid && !sb.flush &&
               (src1_haz || (sb.two_src && src2_haz) || (sb.issue_wb_en && dest_haz));
    issue_fire = sb.issue_valid && sb.issue_wb_en && !hazard_c && !sb.flush &&
                 (sb.issue_dest < ADDR_W'(NUM_REGS));
  end

  always_comb begin
    underflow_d = underflow_q || ((hit & ~busy_now) != '0);
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d[r] = count_q[r];
      if (issue_fire && (sb.issue_dest == ADDR_W'(r)) && !dec[r])
        count_d[r] = count_q[r] + CNT_W'(1);
      else if (dec[r] && !(issue_fire && (sb.issue_dest == ADDR_W'(r))))
        count_d[r] = count_q[r] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= count_d[r];
      underflow_q <= underflow_d;
    end
  end

  assign sb.hazard        = hazard_c;
  assign sb.busy_mask     = busy_now;
  assign sb.underflow_err = underflow_q;

`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_c && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign sb.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NUM_REGS(15), .ADDR_W(4)) sb_if ();
  reg_scoreboard #(.NUM_REGS(15), .ADDR_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .sb(sb_if.slave)
  );

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.issue_valid = 1'b0;
    sb_if.issue_wb_en = 1'b0;
    sb_if.issue_dest  = 4'd15;
    sb_if.src1        = 4'd15;
    sb_if.src2        = 4'd15;
    sb_if.two_src     = 1'b0;
    sb_if.flush       = 1'b0;
    sb_if.wb_en       = 1'b0;
    sb_if.wb_dest     = 4'd15;
  endtask

  task automatic chk_haz(string name, logic exp);
    #1;
    total++;
    if (sb_if.hazard !== exp) $display("FAIL %s hazard got=%b exp=%b", name, sb_if.hazard, exp);
    else passed++;
  endtask

  task automatic chk_busy(string name, logic [14:0] exp);
    total++;
    if (sb_if.busy_mask !== exp)
      $display("FAIL %s busy_mask got=%h exp=%h", name, sb_if.busy_mask, exp);
    else passed++;
  endtask

  task automatic chk_uf(string name, logic exp);
    total++;
    if (sb_if.underflow_err !== exp)
      $display("FAIL %s underflow_err got=%b exp=%b", name, sb_if.underflow_err, exp);
    else passed++;
  endtask

  task automatic issue_one(logic [3:0] d);
    sb_if.issue_valid = 1'b1;
    sb_if.issue_wb_en = 1'b1;
    sb_if.issue_dest  = d;
    step();
    idle();
  endtask

  task automatic wb_one(logic [3:0] d);
    sb_if.wb_en   = 1'b1;
    sb_if.wb_dest = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1'b1;
    #3;
    chk_busy("reset", 15'h0000);
    chk_uf("reset", 1'b0);
    chk_haz("reset", 1'b0);
    step();
    rst = 1'b0;
    step();
    sb_if.issue_valid = 1'b1;
    sb_if.src1 = 4'd3;
    chk_haz("idle_src3", 1'b0);
    idle();
  endtask

  task automatic test_raw();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_wb_en = 1'b1;
    sb_if.issue_dest  = 4'd5;
    chk_haz("raw_issue5", 1'b0);
    step();
    sb_if.issue_wb_en = 1'b0;
    sb_if.src1 = 4'd5;
    chk_haz("raw_c1", 1'b1);
    chk_busy("raw_c1", 15'h0020);
    step();
    chk_haz("raw_c2", 1'b1);
    step();
    sb_if.wb_en = 1'b1;
    sb_if.wb_dest = 4'd5;
    chk_haz("raw_c3_wb", 1'b0);
    chk_busy("raw_c3", 15'h0020);
    step();
    idle();
    #1 chk_busy("raw_c4", 15'h0000);
  endtask

  task automatic test_simul_issue_wb();
    issue_one(4'd7);
    chk_busy("sim_pre", 15'h0080);
    sb_if.issue_valid = 1'b1;
    sb_if.issue_wb_en = 1'b1;
    sb_if.issue_dest  = 4'd7;
    sb_if.wb_en = 1'b1;
    sb_if.wb_dest = 4'd7;
    chk_haz("sim_both", 1'b0);
    step();
    idle();
    #1 chk_busy("sim_after", 15'h0080);
    wb_one(4'd7);
    chk_busy("sim_drain", 15'h0000);
  endtask

  task automatic test_saturation();
    issue_one(4'd2);
    issue_one(4'd2);
    issue_one(4'd2);
    chk_busy("sat_3", 15'h0004);
    sb_if.issue_valid = 1'b1;
    sb_if.issue_wb_en = 1'b1;
    sb_if.issue_dest  = 4'd2;
    chk_haz("sat_4th", 1'b1);
    step();
    chk_haz("sat_4th_held", 1'b1);
    sb_if.wb_en = 1'b1;
    sb_if.wb_dest = 4'd2;
    chk_haz("sat_4th_wb", 1'b0);
    step();
    idle();
    // count must still be 3: two write-backs leave it busy, the third clears it
    wb_one(4'd2);
    chk_busy("sat_wb1", 15'h0004);
    wb_one(4'd2);
    chk_busy("sat_wb2", 15'h0004);
    wb_one(4'd2);
    chk_busy("sat_wb3", 15'h0000);
    chk_uf("sat_nouf", 1'b0);
  endtask

  task automatic test_pc_flush();
    for (int r = 0; r < 15; r++) issue_one(4'(r));
    chk_busy("all_busy", 15'h7FFF);
    sb_if.issue_valid = 1'b1;
    sb_if.src1 = 4'd15;
    sb_if.src2 = 4'd15;
    sb_if.two_src = 1'b1;
    sb_if.issue_wb_en = 1'b1;
    sb_if.issue_dest = 4'd15;
    chk_haz("pc_srcs", 1'b0);
    sb_if.src2 = 4'd4;
    sb_if.two_src = 1'b0;
    chk_haz("src2_unused", 1'b0);
    sb_if.two_src = 1'b1;
    chk_haz("src2_used", 1'b1);
    sb_if.two_src = 1'b0;
    sb_if.src1 = 4'd4;
    sb_if.issue_dest = 4'd4;
    chk_haz("src1_busy", 1'b1);
    sb_if.flush = 1'b1;
    chk_haz("flush", 1'b0);
    step();
    idle();
    // flushed issue to R4 must not have counted
    wb_one(4'd4);
    chk_busy("flush_nocount", 15'h7FEF);
    for (int r = 0; r < 15; r++) if (r != 4) wb_one(4'(r));
    chk_busy("drain_all", 15'h0000);
    chk_uf("drain_nouf", 1'b0);
  endtask

  task automatic test_underflow();
    wb_one(4'd9);
    chk_busy("uf_cnt", 15'h0000);
    chk_uf("uf_set", 1'b1);
    step();
    step();
    chk_uf("uf_sticky", 1'b1);
  endtask

  task automatic test_async_reset();
    issue_one(4'd3);
    chk_busy("ar_pre", 15'h0008);
    #2 rst = 1'b1;
    #1;
    chk_busy("ar_busy", 15'h0000);
    chk_uf("ar_uf", 1'b0);
    #3 rst = 1'b0;
    step();
    sb_if.issue_valid = 1'b1;
    sb_if.src1 = 4'd3;
    chk_haz("ar_src3", 1'b0);
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_simul_issue_wb();
    test_saturation();
    test_pc_flush();
    test_underflow();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
